mig7_app_arbiter: RTL and testbench
===================================

Name: mig7_app_arbiter

Overview:
- Shares the single MIG7 user interface (DDR3 controller, ui_clk domain) between NREQ requesters.
- Each requester issues single-beat read or write requests through a valid/ready handshake. The block arbitrates them round-robin and drives app_en/app_cmd/app_wdf_*.
- Read data returns in MIG order; a tag FIFO routes each beat to the requester that issued it.
- Replaces the stub driver on the MIG local interface.

Parameters:
NREQ, 2, number of requesters (2..8)
AW, 28, app_addr width
DW, 128, data width; mask width is DW/8
RD_DEPTH, 16, max outstanding reads, power of 2

Ports:
clk  in  1  MIG ui_clk
rst_n  in  1  synchronous active-low reset
init_calib_complete  in  1  MIG calibration done
req_valid  in  NREQ  request present, one bit per requester
req_ready  out  NREQ  request accepted this cycle (one-hot or zero)
req_write  in  NREQ  1 = write, 0 = read
req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
req_wdata  in  NREQ*DW  packed write data
req_wmask  in  NREQ*DW/8  packed byte masks (1 = byte not written)
rsp_valid  out  NREQ  read data valid, one-hot
rsp_data  out  DW  read data, common to all requesters
err_unexp_rd  out  1  sticky: read data arrived with tag FIFO empty
app_addr/app_cmd/app_en  out  AW/3/1  MIG command
app_wdf_data/app_wdf_mask/app_wdf_wren/app_wdf_end  out  DW/DW/8/1/1  MIG write data
app_rd_data/app_rd_data_valid/app_rd_data_end  in  DW/1/1  MIG read return
app_rdy/app_wdf_rdy  in  1/1  MIG flow control
app_sr_req/app_ref_req/app_zq_req  out  1 each  tied 0
app_sr_active/app_ref_ack/app_zq_ack  in  1 each  ignored

Behaviour:
- Reset (rst_n=0 at a clk edge): FSM to IDLE; all outputs 0; tag FIFO emptied; err_unexp_rd cleared; round-robin pointer set so requester 0 has highest priority.
- Reset mid-transaction abandons the in-flight command and any outstanding read tags without completion. The MIG is reset alongside and is not required to finish.
- FSM states:
  - IDLE: no grant while init_calib_complete=0.
    - Eligible requesters: req_valid=1, and for reads, outstanding count < RD_DEPTH.
    - Winner: first eligible at or after pointer, wrapping NREQ-1 -> 0.
    - On a winner: req_ready[winner]=1 for exactly that cycle (combinational from the registered state). addr, cmd, wdata and mask are latched; pointer becomes winner+1 mod NREQ. Go to ISSUE.
  - ISSUE: app_en=1, app_cmd=3'b000 for write or 3'b001 for read, app_addr from the latch.
    - For writes, app_wdf_wren=app_wdf_end=1 with the latched data and mask.
    - cmd_done sets when app_en&app_rdy; wdf_done sets when app_wdf_wren&app_wdf_rdy.
    - app_en drops the cycle after cmd_done; app_wdf_wren drops the cycle after wdf_done. The two may complete in any order or together.
    - Reads need only cmd_done. On read acceptance, push the winner index to the tag FIFO.
    - When all required parts are done, go to IDLE.
- Throughput: at most one request per 2 cycles. Latency from the req_ready cycle to the first app_en is 1 cycle.
- Read return: app_rd_data_valid=1 pops the tag and registers the beat. Next cycle: rsp_valid[tag]=1 and rsp_data=app_rd_data. Latency is 1.
- A push and a pop in the same cycle are both performed; the count is unchanged.
- app_rd_data_valid with an empty FIFO: no rsp_valid; err_unexp_rd set until reset.
- The outstanding count equals FIFO occupancy and never exceeds RD_DEPTH.
- A full FIFO excludes reads from arbitration only; writes are still granted.
- init_calib_complete falling during ISSUE: the current command completes; no new grants.
- rsp_data holds its last value when rsp_valid=0.
- app_rd_data_end is ignored (BL8, one beat per command).

Test Plan:
- init_calib_complete=0, req_valid=2'b11 for 20 cycles -> req_ready stays 0 and app_en stays 0. Raise calib -> req_ready=2'b01 next cycle.
- Req0 write addr 0x100, data 0xA5..A5, mask 0; app_wdf_rdy=1, app_rdy held 0 for 3 cycles -> wdf handshake in cycle 1. Then app_wdf_wren=0 while app_en=1 until app_rdy; app_cmd=0; back to IDLE.
- Both requesters valid continuously, writes, MIG always ready -> grants alternate 0,1,0,1; 8 requests complete in 16 cycles.
- Req1 issues 16 reads with no read return -> the 17th read is not granted. A req0 write is still granted. After one app_rd_data_valid, the read is granted.
- Interleave reads from req0 (addr 0x10) then req1 (addr 0x20); MIG returns D0, D1 -> rsp_valid=01 with D0, then 10 with D1, each 1 cycle after app_rd_data_valid.
- app_rd_data_valid pulse with no reads outstanding -> err_unexp_rd=1 and remains 1. rst_n=0 for 1 cycle -> cleared, FIFO empty, pointer at requester 0.

Source files
------------

// File: rtl/mig7_app_arbiter.sv
// Round-robin arbiter sharing one MIG7 user interface between NREQ single-beat requesters.
// A tag FIFO routes in-order read returns back to the requester that issued each read.
module mig7_app_arbiter #(
  parameter int NREQ     = 2,
  parameter int AW       = 28,
  parameter int DW       = 128,
  parameter int RD_DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_init_calib_complete,
  input  logic [NREQ-1:0]        i_req_valid,
  output logic [NREQ-1:0]        o_req_ready,
  input  logic [NREQ-1:0]        i_req_write,
  input  logic [NREQ*AW-1:0]     i_req_addr,
  input  logic [NREQ*DW-1:0]     i_req_wdata,
  input  logic [NREQ*(DW/8)-1:0] i_req_wmask,
  output logic [NREQ-1:0]        o_rsp_valid,
  output logic [DW-1:0]          o_rsp_data,
  output logic                   o_err_unexp_rd,
  output logic [AW-1:0]          o_app_addr,
  output logic [2:0]             o_app_cmd,
  output logic                   o_app_en,
  output logic [DW-1:0]          o_app_wdf_data,
  output logic [DW/8-1:0]        o_app_wdf_mask,
  output logic                   o_app_wdf_wren,
  output logic                   o_app_wdf_end,
  input  logic [DW-1:0]          i_app_rd_data,
  input  logic                   i_app_rd_data_valid,
  input  logic                   i_app_rd_data_end,
  input  logic                   i_app_rdy,
  input  logic                   i_app_wdf_rdy,
  output logic                   o_app_sr_req,
  output logic                   o_app_ref_req,
  output logic                   o_app_zq_req,
  input  logic                   i_app_sr_active,
  input  logic                   i_app_ref_ack,
  input  logic                   i_app_zq_ack
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
  localparam int CW = TW + 1;
  localparam int MW = DW / 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t            r_state;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_win;
  logic              r_app_en;
  logic              r_wdf_wren;
  logic [2:0]        r_app_cmd;
  logic [AW-1:0]     r_addr;
  logic [DW-1:0]     r_wdata;
  logic [MW-1:0]     r_wmask;

  logic [PW-1:0]     r_tag_mem [RD_DEPTH];
  logic [TW-1:0]     r_tag_wr;
  logic [TW-1:0]     r_tag_rd;
  logic [CW-1:0]     r_count;
  logic [NREQ-1:0]   r_rsp_valid;
  logic [DW-1:0]     r_rsp_data;
  logic              r_err;

  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [NREQ-1:0]   w_elig;
  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [PW-1:0]     w_off;
  logic [PW:0]       w_sum;
  logic [PW-1:0]     w_win;
  logic [PW-1:0]     w_win_inc;
  logic              w_grant;
  logic              w_cmd_fin;
  logic              w_wdf_fin;
  logic              w_push;
  logic              w_pop;
  logic              w_unused_ok;

  assign w_fifo_full  = (r_count == CW'(RD_DEPTH));
  assign w_fifo_empty = (r_count == CW'(0));
  assign w_elig       = i_req_valid & (i_req_write | {NREQ{~w_fifo_full}});
  assign w_dbl        = {w_elig, w_elig} >> r_ptr;
  assign w_rot        = w_dbl[NREQ-1:0];

  // Find the first eligible requester at or after the round-robin pointer.
  always_comb begin
    w_off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_off = w_rot[i] ? PW'(i) : w_off;
    end
    w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
    w_win     = (w_sum >= (PW+1)'(NREQ)) ? PW'(w_sum - (PW+1)'(NREQ)) : PW'(w_sum);
    w_win_inc = (w_win == PW'(NREQ - 1)) ? '0 : w_win + PW'(1);
  end

  assign w_grant     = (r_state == ST_IDLE) & i_init_calib_complete & (|w_rot);
  assign o_req_ready = w_grant ? (NREQ'(1) << w_win) : '0;

  // Each half of the transaction is finished once its strobe is already low or handshakes now.
  assign w_cmd_fin = ~r_app_en | i_app_rdy;
  assign w_wdf_fin = ~r_wdf_wren | i_app_wdf_rdy;
  assign w_push    = (r_state == ST_ISSUE) & r_app_en & i_app_rdy & (r_app_cmd == 3'b001);
  assign w_pop     = i_app_rd_data_valid & ~w_fifo_empty;

  // Arbitration / issue FSM with registered MIG command and write-data strobes.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_win      <= '0;
      r_app_en   <= 1'b0;
      r_wdf_wren <= 1'b0;
      r_app_cmd  <= 3'b000;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_win      <= w_win;
            r_ptr      <= w_win_inc;
            r_addr     <= i_req_addr[w_win*AW +: AW];
            r_wdata    <= i_req_wdata[w_win*DW +: DW];
            r_wmask    <= i_req_wmask[w_win*MW +: MW];
            r_app_cmd  <= i_req_write[w_win] ? 3'b000 : 3'b001;
            r_app_en   <= 1'b1;
            r_wdf_wren <= i_req_write[w_win];
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (r_app_en && i_app_rdy) begin
            r_app_en <= 1'b0;
          end
          if (r_wdf_wren && i_app_wdf_rdy) begin
            r_wdf_wren <= 1'b0;
          end
          if (w_cmd_fin && w_wdf_fin) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Tag storage; stale entries are harmless because reset clears the pointers.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_tag_mem[r_tag_wr] <= r_win;
    end
  end

  // Tag FIFO pointers, occupancy and read-return routing.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tag_wr    <= '0;
      r_tag_rd    <= '0;
      r_count     <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_push) begin
        r_tag_wr <= r_tag_wr + TW'(1);
      end
      if (w_pop) begin
        r_tag_rd <= r_tag_rd + TW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (i_app_rd_data_valid) begin
        if (w_fifo_empty) begin
          r_err       <= 1'b1;
          r_rsp_valid <= '0;
        end else begin
          r_rsp_valid <= NREQ'(1) << r_tag_mem[r_tag_rd];
          r_rsp_data  <= i_app_rd_data;
        end
      end else begin
        r_rsp_valid <= '0;
      end
    end
  end

  assign o_app_en       = r_app_en;
  assign o_app_cmd      = r_app_cmd;
  assign o_app_addr     = r_addr;
  assign o_app_wdf_data = r_wdata;
  assign o_app_wdf_mask = r_wmask;
  assign o_app_wdf_wren = r_wdf_wren;
  assign o_app_wdf_end  = r_wdf_wren;
  assign o_rsp_valid    = r_rsp_valid;
  assign o_rsp_data     = r_rsp_data;
  assign o_err_unexp_rd = r_err;
  assign o_app_sr_req   = 1'b0;
  assign o_app_ref_req  = 1'b0;
  assign o_app_zq_req   = 1'b0;

  assign w_unused_ok = &{1'b0, i_app_rd_data_end, i_app_sr_active, i_app_ref_ack, i_app_zq_ack};

endmodule

// File: tb/tb_mig7_app_arbiter.sv
// Self-checking bench for mig7_app_arbiter: inputs change 1 ns after posedge, outputs sampled at negedge.
// Read responses and issued addresses are checked against queues filled when stimulus is driven.
module tb_mig7_app_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 28;
  localparam int DW   = 128;
  localparam int MW   = DW / 8;
  localparam int RDD  = 16;

  typedef struct packed {
    logic [NREQ-1:0] who;
    logic [DW-1:0]   data;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0;
  logic              calib = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_write = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ*MW-1:0] req_wmask = '0;
  logic [NREQ-1:0]   rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              err_unexp_rd;
  logic [AW-1:0]     app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic [DW-1:0]     app_wdf_data;
  logic [MW-1:0]     app_wdf_mask;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic [DW-1:0]     app_rd_data = '0;
  logic              app_rd_data_valid = 1'b0;
  logic              app_rdy = 1'b0;
  logic              app_wdf_rdy = 1'b0;
  logic              app_sr_req, app_ref_req, app_zq_req;

  int n_checks = 0;
  int n_errs   = 0;
  rsp_t          rsp_q[$];
  logic [AW-1:0] addr_q[$];

  mig7_app_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_DEPTH(RDD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_init_calib_complete(calib),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_wmask(req_wmask),
    .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_err_unexp_rd(err_unexp_rd),
    .o_app_addr(app_addr), .o_app_cmd(app_cmd), .o_app_en(app_en),
    .o_app_wdf_data(app_wdf_data), .o_app_wdf_mask(app_wdf_mask),
    .o_app_wdf_wren(app_wdf_wren), .o_app_wdf_end(app_wdf_end),
    .i_app_rd_data(app_rd_data), .i_app_rd_data_valid(app_rd_data_valid),
    .i_app_rd_data_end(1'b0), .i_app_rdy(app_rdy), .i_app_wdf_rdy(app_wdf_rdy),
    .o_app_sr_req(app_sr_req), .o_app_ref_req(app_ref_req), .o_app_zq_req(app_zq_req),
    .i_app_sr_active(1'b0), .i_app_ref_ack(1'b0), .i_app_zq_ack(1'b0)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    calib = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    req_wmask = '0; app_rd_data = '0; app_rd_data_valid = 1'b0; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
  endtask

  task automatic do_reset();
    cyc();
    rst_n = 1'b0;
    clear_inputs();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    smp();
    n_checks++;
    if ({req_ready, app_en, app_wdf_wren, app_wdf_end, app_cmd} !== '0) begin
      n_errs++;
      $display("FAIL reset_ctrl: got ready=%b en=%b wren=%b end=%b cmd=%b, want all 0", req_ready, app_en, app_wdf_wren, app_wdf_end, app_cmd);
    end
    n_checks++;
    if ({rsp_valid, rsp_data, err_unexp_rd, app_addr} !== '0) begin
      n_errs++;
      $display("FAIL reset_data: got rsp_valid=%b rsp_data=%h err=%b addr=%h, want all 0", rsp_valid, rsp_data, err_unexp_rd, app_addr);
    end
    n_checks++;
    if ({app_sr_req, app_ref_req, app_zq_req} !== 3'b000) begin
      n_errs++;
      $display("FAIL reset_maint: got %b%b%b want 000", app_sr_req, app_ref_req, app_zq_req);
    end
  endtask

  task automatic test_calib();
    do_reset();
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    req_valid = 2'b11; req_write = 2'b11;
    for (int c = 0; c < 20; c++) begin
      smp();
      n_checks++;
      if ({req_ready, app_en} !== 3'b000) begin
        n_errs++;
        $display("FAIL calib_hold c=%0d: got ready=%b en=%b want 00/0", c, req_ready, app_en);
      end
      cyc();
    end
    calib = 1'b1;
    smp();
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_errs++;
      $display("FAIL calib_first_grant: got %b want 01", req_ready);
    end
    cyc();
    req_valid = 2'b00;
    smp();
    n_checks++;
    if (app_en !== 1'b1) begin
      n_errs++;
      $display("FAIL calib_issue: got app_en=%b want 1", app_en);
    end
    cyc();
    cyc();
  endtask

  task automatic test_write_stall();
    logic [DW-1:0] pat;
    pat = {16{8'hA5}};
    do_reset();
    calib = 1'b1; app_rdy = 1'b0; app_wdf_rdy = 1'b1;
    req_valid = 2'b01; req_write = 2'b01;
    req_addr[0 +: AW] = 28'h100; req_wdata[0 +: DW] = pat; req_wmask[0 +: MW] = '0;
    smp();
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_errs++;
      $display("FAIL ws_grant: got %b want 01", req_ready);
    end
    cyc();
    req_valid = 2'b00;
    smp();
    n_checks++;
    if ({app_en, app_wdf_wren, app_wdf_end, app_cmd, app_addr} !== {3'b111, 3'b000, 28'h100}) begin
      n_errs++;
      $display("FAIL ws_issue: got en=%b wren=%b end=%b cmd=%b addr=%h want 1 1 1 000 100", app_en, app_wdf_wren, app_wdf_end, app_cmd, app_addr);
    end
    n_checks++;
    if ({app_wdf_data, app_wdf_mask} !== {pat, {MW{1'b0}}}) begin
      n_errs++;
      $display("FAIL ws_wdata: got data=%h mask=%h want %h 0", app_wdf_data, app_wdf_mask, pat);
    end
    for (int c = 0; c < 3; c++) begin
      cyc();
      if (c == 2) app_rdy = 1'b1;
      smp();
      n_checks++;
      if ({app_en, app_wdf_wren, app_wdf_end} !== 3'b100) begin
        n_errs++;
        $display("FAIL ws_wait c=%0d: got en=%b wren=%b end=%b want 1 0 0", c, app_en, app_wdf_wren, app_wdf_end);
      end
    end
    cyc();
    req_valid = 2'b10; req_write = 2'b10;
    smp();
    n_checks++;
    if ({app_en, req_ready} !== 3'b010) begin
      n_errs++;
      $display("FAIL ws_back_idle: got en=%b ready=%b want 0 10", app_en, req_ready);
    end
    cyc();
    req_valid = 2'b00;
    cyc();
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [NREQ-1:0] exp_ready;
    int n_acc;
    logic [AW-1:0] ea;
    n_acc = 0;
    do_reset();
    calib = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    req_valid = 2'b11; req_write = 2'b11;
    req_addr[0 +: AW] = 28'h200; req_addr[AW +: AW] = 28'h300;
    for (int c = 0; c < 16; c++) begin
      smp();
      exp_ready = (c % 2 != 0) ? 2'b00 : (((c / 2) % 2 == 0) ? 2'b01 : 2'b10);
      n_checks++;
      if (req_ready !== exp_ready) begin
        n_errs++;
        $display("FAIL b2b_ready c=%0d: got %b want %b", c, req_ready, exp_ready);
      end
      if (exp_ready == 2'b01) addr_q.push_back(28'h200);
      if (exp_ready == 2'b10) addr_q.push_back(28'h300);
      if (app_en === 1'b1) begin
        n_acc++;
        n_checks++;
        if (addr_q.size() == 0) begin
          n_errs++;
          $display("FAIL b2b_addr c=%0d: got unexpected command addr=%h want none", c, app_addr);
        end else begin
          ea = addr_q.pop_front();
          if (app_addr !== ea) begin
            n_errs++;
            $display("FAIL b2b_addr c=%0d: got %h want %h", c, app_addr, ea);
          end
        end
      end
      cyc();
    end
    req_valid = 2'b00;
    n_checks++;
    if (n_acc != 8 || addr_q.size() != 0) begin
      n_errs++;
      $display("FAIL b2b_count: got %0d commands (%0d pending) want 8 (0)", n_acc, addr_q.size());
    end
    addr_q.delete();
    cyc();
    cyc();
  endtask

  task automatic test_fifo_full();
    rsp_t e;
    logic [DW-1:0] dx;
    dx = {4{32'hCAFE_0017}};
    do_reset();
    calib = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    req_valid = 2'b10; req_write = 2'b00; req_addr[AW +: AW] = 28'h400;
    for (int c = 0; c < 36; c++) begin
      smp();
      n_checks++;
      if (req_ready !== ((c < 32 && c % 2 == 0) ? 2'b10 : 2'b00)) begin
        n_errs++;
        $display("FAIL full_ready c=%0d: got %b want %b", c, req_ready, (c < 32 && c % 2 == 0) ? 2'b10 : 2'b00);
      end
      cyc();
    end
    req_valid = 2'b11; req_write = 2'b01;
    smp();
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_errs++;
      $display("FAIL full_write_grant: got %b want 01", req_ready);
    end
    cyc();
    req_valid = 2'b10;
    smp();
    n_checks++;
    if ({req_ready, app_en, app_cmd} !== {2'b00, 1'b1, 3'b000}) begin
      n_errs++;
      $display("FAIL full_write_issue: got ready=%b en=%b cmd=%b want 00 1 000", req_ready, app_en, app_cmd);
    end
    cyc();
    smp();
    n_checks++;
    if (req_ready !== 2'b00) begin
      n_errs++;
      $display("FAIL full_still_blocked: got %b want 00", req_ready);
    end
    cyc();
    app_rd_data_valid = 1'b1; app_rd_data = dx;
    rsp_q.push_back('{who: 2'b10, data: dx});
    cyc();
    app_rd_data_valid = 1'b0;
    smp();
    n_checks++;
    if (req_ready !== 2'b10) begin
      n_errs++;
      $display("FAIL full_unblocked: got %b want 10", req_ready);
    end
    n_checks++;
    if (rsp_q.size() == 0) begin
      n_errs++;
      $display("FAIL full_rsp: scoreboard empty");
    end else begin
      e = rsp_q.pop_front();
      if ({rsp_valid, rsp_data} !== {e.who, e.data}) begin
        n_errs++;
        $display("FAIL full_rsp: got %b %h want %b %h", rsp_valid, rsp_data, e.who, e.data);
      end
    end
    cyc();
    req_valid = 2'b00;
    cyc();
    cyc();
  endtask

  task automatic test_interleave();
    rsp_t e;
    logic [DW-1:0] d0, d1;
    d0 = {4{32'hD0D0_0000}};
    d1 = {4{32'hD1D1_1111}};
    do_reset();
    calib = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    req_valid = 2'b01; req_write = 2'b00; req_addr[0 +: AW] = 28'h10;
    smp();
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_errs++;
      $display("FAIL il_grant0: got %b want 01", req_ready);
    end
    cyc();
    req_valid = 2'b10; req_addr[AW +: AW] = 28'h20;
    smp();
    n_checks++;
    if ({req_ready, app_en, app_cmd, app_addr} !== {2'b00, 1'b1, 3'b001, 28'h10}) begin
      n_errs++;
      $display("FAIL il_issue0: got ready=%b en=%b cmd=%b addr=%h want 00 1 001 10", req_ready, app_en, app_cmd, app_addr);
    end
    cyc();
    smp();
    n_checks++;
    if (req_ready !== 2'b10) begin
      n_errs++;
      $display("FAIL il_grant1: got %b want 10", req_ready);
    end
    cyc();
    req_valid = 2'b00;
    smp();
    n_checks++;
    if ({app_en, app_cmd, app_addr} !== {1'b1, 3'b001, 28'h20}) begin
      n_errs++;
      $display("FAIL il_issue1: got en=%b cmd=%b addr=%h want 1 001 20", app_en, app_cmd, app_addr);
    end
    cyc();
    app_rd_data_valid = 1'b1; app_rd_data = d0;
    rsp_q.push_back('{who: 2'b01, data: d0});
    for (int c = 0; c < 2; c++) begin
      cyc();
      if (c == 0) begin
        app_rd_data = d1;
        rsp_q.push_back('{who: 2'b10, data: d1});
      end else begin
        app_rd_data_valid = 1'b0;
      end
      smp();
      n_checks++;
      if (rsp_q.size() == 0) begin
        n_errs++;
        $display("FAIL il_rsp c=%0d: scoreboard empty", c);
      end else begin
        e = rsp_q.pop_front();
        if ({rsp_valid, rsp_data} !== {e.who, e.data}) begin
          n_errs++;
          $display("FAIL il_rsp c=%0d: got %b %h want %b %h", c, rsp_valid, rsp_data, e.who, e.data);
        end
      end
    end
    cyc();
    smp();
    n_checks++;
    if ({rsp_valid, rsp_data, err_unexp_rd} !== {2'b00, d1, 1'b0}) begin
      n_errs++;
      $display("FAIL il_hold: got %b %h err=%b want 00 %h 0", rsp_valid, rsp_data, err_unexp_rd, d1);
    end
  endtask

  task automatic test_unexp();
    cyc();
    app_rd_data_valid = 1'b1; app_rd_data = {4{32'hBAD0_BAD0}};
    cyc();
    app_rd_data_valid = 1'b0;
    smp();
    n_checks++;
    if ({err_unexp_rd, rsp_valid} !== 3'b100) begin
      n_errs++;
      $display("FAIL unexp_set: got err=%b rsp_valid=%b want 1 00", err_unexp_rd, rsp_valid);
    end
    cyc();
    cyc();
    cyc();
    req_valid = 2'b01; req_write = 2'b00;
    smp();
    n_checks++;
    if ({err_unexp_rd, req_ready} !== 3'b101) begin
      n_errs++;
      $display("FAIL unexp_sticky: got err=%b ready=%b want 1 01", err_unexp_rd, req_ready);
    end
    cyc();
    req_valid = 2'b00;
    cyc();
    cyc();
    do_reset();
    smp();
    n_checks++;
    if ({err_unexp_rd, app_en} !== 2'b00) begin
      n_errs++;
      $display("FAIL unexp_clear: got err=%b en=%b want 0 0", err_unexp_rd, app_en);
    end
    cyc();
    calib = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    req_valid = 2'b11; req_write = 2'b11;
    smp();
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_errs++;
      $display("FAIL unexp_ptr_reset: got %b want 01", req_ready);
    end
    cyc();
    req_valid = 2'b00;
    cyc();
    cyc();
    app_rd_data_valid = 1'b1;
    cyc();
    app_rd_data_valid = 1'b0;
    smp();
    n_checks++;
    if ({err_unexp_rd, rsp_valid} !== 3'b100) begin
      n_errs++;
      $display("FAIL unexp_fifo_empty: got err=%b rsp_valid=%b want 1 00", err_unexp_rd, rsp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_calib();
    test_write_stall();
    test_back_to_back();
    test_fifo_full();
    test_interleave();
    test_unexp();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
